// File: rtl/stim_pkg.sv
// Shared types for the stimulation pulse sequencer: FSM state encoding and the
// per-state output table (phase outputs are polarity-neutral here).
package stim_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StRest,
    StExtPre,
    StPh1,
    StIpd,
    StPh2,
    StDis,
    StExtPost
  } stim_state_e;

  typedef struct packed {
    logic en;
    logic ph1;
    logic ph2;
    logic dis;
  } stim_out_t;

  // Field order {en, ph1, ph2, dis}; ph1/ph2 are mapped to CAT/ANO by polarity.
  localparam stim_out_t StimOutTable [8] = '{
    4'b0000,  // StIdle
    4'b0000,  // StRest
    4'b1000,  // StExtPre
    4'b1100,  // StPh1
    4'b1000,  // StIpd
    4'b1010,  // StPh2
    4'b1001,  // StDis
    4'b1000   // StExtPost
  };

endpackage

// File: rtl/stim_timer.sv
// Loadable down-counter; expired_o is high while the count sits at zero, so a
// load value of N-1 yields an N-cycle dwell.
module stim_timer #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  output logic             expired_o
);

  logic [CNT_W-1:0] count_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else if (load_i) begin
      count_q <= load_val_i;
    end else if (count_q != '0) begin
      count_q <= count_q - 1'b1;
    end
  end

  assign expired_o = (count_q == '0);

endmodule

// File: rtl/stim_sequencer.sv
// Biphasic stimulation pulse-train sequencer. Config is shadowed at start; all
// outputs are registered from the next state so they move with the transition.
module stim_sequencer
  import stim_pkg::*;
#(
  parameter int unsigned MAG_W    = 5,
  parameter int unsigned CNT_W    = 16,
  parameter int unsigned NPULSE_W = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                stop,
  input  logic [CNT_W-1:0]    cfg_rest,
  input  logic [CNT_W-1:0]    cfg_ext,
  input  logic [CNT_W-1:0]    cfg_ph1,
  input  logic [CNT_W-1:0]    cfg_ipd,
  input  logic [CNT_W-1:0]    cfg_ph2,
  input  logic [CNT_W-1:0]    cfg_dis,
  input  logic [MAG_W-1:0]    cfg_mag,
  input  logic                cfg_ramp,
  input  logic                cfg_anodic_first,
  input  logic [NPULSE_W-1:0] cfg_npulse,
  output logic                EN_ST,
  output logic                CAT_ST,
  output logic                ANO_ST,
  output logic                DIS_ST,
  output logic [MAG_W-1:0]    MAG_ST,
  output logic                busy,
  output logic                done
);

  stim_state_e state_q, state_d;

  logic [CNT_W-1:0]    sh_rest_q, sh_ext_q, sh_ph1_q, sh_ipd_q, sh_ph2_q, sh_dis_q;
  logic [CNT_W-1:0]    sh_rest_d, sh_ext_d, sh_ph1_d, sh_ipd_d, sh_ph2_d, sh_dis_d;
  logic [MAG_W-1:0]    sh_mag_q, sh_mag_d, mag_q, mag_d;
  logic                sh_ramp_q, sh_ramp_d, sh_af_q, sh_af_d;
  logic [NPULSE_W-1:0] sh_npulse_q, sh_npulse_d, cnt_q, cnt_d, cnt_inc;
  logic                pend_q, pend_d, stop_now, last_pulse;
  logic                en_q, cat_q, ano_q, dis_q, busy_q, done_q;
  logic                en_d, cat_d, ano_d, dis_d, busy_d, done_d;
  logic                timer_load, timer_expired;
  logic [CNT_W-1:0]    timer_val, dur_sel;
  stim_out_t           out;

  stim_timer #(
    .CNT_W (CNT_W)
  ) u_timer (
    .clk_i      (clk),
    .rst_i      (rst),
    .load_i     (timer_load),
    .load_val_i (timer_val),
    .expired_o  (timer_expired)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      sh_rest_q   <= '0;
      sh_ext_q    <= '0;
      sh_ph1_q    <= '0;
      sh_ipd_q    <= '0;
      sh_ph2_q    <= '0;
      sh_dis_q    <= '0;
      sh_mag_q    <= '0;
      sh_ramp_q   <= 1'b0;
      sh_af_q     <= 1'b0;
      sh_npulse_q <= '0;
      cnt_q       <= '0;
      mag_q       <= '0;
      pend_q      <= 1'b0;
      en_q        <= 1'b0;
      cat_q       <= 1'b0;
      ano_q       <= 1'b0;
      dis_q       <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      sh_rest_q   <= sh_rest_d;
      sh_ext_q    <= sh_ext_d;
      sh_ph1_q    <= sh_ph1_d;
      sh_ipd_q    <= sh_ipd_d;
      sh_ph2_q    <= sh_ph2_d;
      sh_dis_q    <= sh_dis_d;
      sh_mag_q    <= sh_mag_d;
      sh_ramp_q   <= sh_ramp_d;
      sh_af_q     <= sh_af_d;
      sh_npulse_q <= sh_npulse_d;
      cnt_q       <= cnt_d;
      mag_q       <= mag_d;
      pend_q      <= pend_d;
      en_q        <= en_d;
      cat_q       <= cat_d;
      ano_q       <= ano_d;
      dis_q       <= dis_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    sh_rest_d   = sh_rest_q;
    sh_ext_d    = sh_ext_q;
    sh_ph1_d    = sh_ph1_q;
    sh_ipd_d    = sh_ipd_q;
    sh_ph2_d    = sh_ph2_q;
    sh_dis_d    = sh_dis_q;
    sh_mag_d    = sh_mag_q;
    sh_ramp_d   = sh_ramp_q;
    sh_af_d     = sh_af_q;
    sh_npulse_d = sh_npulse_q;
    cnt_d       = cnt_q;
    mag_d       = mag_q;
    stop_now    = stop | pend_q;
    cnt_inc     = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
    last_pulse  = (sh_npulse_q != '0) && (cnt_inc == sh_npulse_q);

    case (state_q)
      StIdle: begin
        if (start) begin
          state_d     = StRest;
          sh_rest_d   = cfg_rest;
          sh_ext_d    = cfg_ext;
          sh_ph1_d    = cfg_ph1;
          sh_ipd_d    = cfg_ipd;
          sh_ph2_d    = cfg_ph2;
          sh_dis_d    = cfg_dis;
          sh_mag_d    = cfg_mag;
          sh_ramp_d   = cfg_ramp;
          sh_af_d     = cfg_anodic_first;
          sh_npulse_d = cfg_npulse;
          cnt_d       = '0;
          mag_d       = cfg_ramp ? '0 : cfg_mag;
        end
      end
      StRest: begin
        if (stop_now) begin
          state_d = StIdle;
        end else if (timer_expired) begin
          state_d = StExtPre;
        end
      end
      StExtPre: if (timer_expired) state_d = StPh1;
      StPh1:    if (timer_expired) state_d = StIpd;
      StIpd:    if (timer_expired) state_d = StPh2;
      StPh2:    if (timer_expired) state_d = StDis;
      StDis:    if (timer_expired) state_d = StExtPost;
      StExtPost: begin
        if (timer_expired) begin
          cnt_d = cnt_inc;
          if (sh_ramp_q && (mag_q < sh_mag_q)) begin
            mag_d = mag_q + 1'b1;
          end
          state_d = (stop_now || last_pulse) ? StIdle : StRest;
        end
      end
      default: state_d = StIdle;
    endcase

    // A stop seen while busy is remembered until the train actually ends.
    if (state_d == StIdle) begin
      pend_d = 1'b0;
    end else if (stop && (state_q != StIdle)) begin
      pend_d = 1'b1;
    end else begin
      pend_d = pend_q;
    end

    case (state_d)
      StRest:              dur_sel = sh_rest_d;
      StExtPre, StExtPost: dur_sel = sh_ext_d;
      StPh1:               dur_sel = sh_ph1_d;
      StIpd:               dur_sel = sh_ipd_d;
      StPh2:               dur_sel = sh_ph2_d;
      StDis:               dur_sel = sh_dis_d;
      default:             dur_sel = '0;
    endcase
    // A zero duration behaves as one cycle.
    timer_val  = (dur_sel == '0) ? '0 : dur_sel - 1'b1;
    timer_load = (state_d != state_q);
  end

  always_comb begin
    out    = StimOutTable[state_d];
    en_d   = out.en;
    cat_d  = sh_af_d ? out.ph2 : out.ph1;
    ano_d  = sh_af_d ? out.ph1 : out.ph2;
    dis_d  = out.dis;
    busy_d = (state_d != StIdle);
    done_d = (state_d == StIdle) && (state_q != StIdle);
  end

  assign EN_ST  = en_q;
  assign CAT_ST = cat_q;
  assign ANO_ST = ano_q;
  assign DIS_ST = dis_q;
  assign MAG_ST = mag_q;
  assign busy   = busy_q;
  assign done   = done_q;

endmodule

// File: tb/tb_stim_sequencer.sv
// Scoreboard bench: each train's expected cycle-by-cycle outputs come from a
// pulse-level model and are checked by an independent negedge monitor.
module tb_stim_sequencer;

  localparam int MAG_W    = 5;
  localparam int CNT_W    = 16;
  localparam int NPULSE_W = 8;

  logic                clk = 1'b0;
  logic                rst, start, stop;
  logic [CNT_W-1:0]    cfg_rest, cfg_ext, cfg_ph1, cfg_ipd, cfg_ph2, cfg_dis;
  logic [MAG_W-1:0]    cfg_mag;
  logic                cfg_ramp, cfg_anodic_first;
  logic [NPULSE_W-1:0] cfg_npulse;
  logic                EN_ST, CAT_ST, ANO_ST, DIS_ST, busy, done;
  logic [MAG_W-1:0]    MAG_ST;

  stim_sequencer #(
    .MAG_W    (MAG_W),
    .CNT_W    (CNT_W),
    .NPULSE_W (NPULSE_W)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .start            (start),
    .stop             (stop),
    .cfg_rest         (cfg_rest),
    .cfg_ext          (cfg_ext),
    .cfg_ph1          (cfg_ph1),
    .cfg_ipd          (cfg_ipd),
    .cfg_ph2          (cfg_ph2),
    .cfg_dis          (cfg_dis),
    .cfg_mag          (cfg_mag),
    .cfg_ramp         (cfg_ramp),
    .cfg_anodic_first (cfg_anodic_first),
    .cfg_npulse       (cfg_npulse),
    .EN_ST            (EN_ST),
    .CAT_ST           (CAT_ST),
    .ANO_ST           (ANO_ST),
    .DIS_ST           (DIS_ST),
    .MAG_ST           (MAG_ST),
    .busy             (busy),
    .done             (done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic             en;
    logic             cat;
    logic             ano;
    logic             dis;
    logic [MAG_W-1:0] mag;
    logic             busy;
    logic             done;
  } vec_t;

  typedef struct {
    int rest; int ext; int ph1; int ipd; int ph2; int dis;
    int mag; int npulse; bit ramp; bit af;
  } cfg_t;

  vec_t             exp_q[$];
  vec_t             plan_q[$];
  int               n_tests = 0;
  int               n_fail  = 0;
  bit               chk_en  = 1'b0;
  logic [MAG_W-1:0] idle_mag = '0;

  function automatic string fmt(vec_t v);
    return $sformatf("en=%b cat=%b ano=%b dis=%b mag=%0d busy=%b done=%b",
                     v.en, v.cat, v.ano, v.dis, v.mag, v.busy, v.done);
  endfunction

  function automatic int cl(int x);
    return (x == 0) ? 1 : x;
  endfunction

  function automatic int period(cfg_t c);
    return cl(c.rest) + 2 * cl(c.ext) + cl(c.ph1) + cl(c.ipd) + cl(c.ph2) + cl(c.dis);
  endfunction

  function automatic vec_t mkvec(logic [3:0] o, int mag, bit b, bit d);
    vec_t v;
    v.en   = o[3];
    v.cat  = o[2];
    v.ano  = o[1];
    v.dis  = o[0];
    v.mag  = MAG_W'(mag);
    v.busy = b;
    v.done = d;
    return v;
  endfunction

  // Expected trace: entry t is what the DUT shows after the t-th edge past start.
  function automatic void build_plan(cfg_t c, int stop_edge);
    int         len [7];
    logic [3:0] outs [7];
    logic [3:0] first, second;
    int         t = 0, pulse = 0, mag;
    bit         pend = 0, quit = 0;
    first  = c.af ? 4'b1010 : 4'b1100;
    second = c.af ? 4'b1100 : 4'b1010;
    len  = '{cl(c.rest), cl(c.ext), cl(c.ph1), cl(c.ipd), cl(c.ph2), cl(c.dis), cl(c.ext)};
    outs = '{4'b0000, 4'b1000, first, 4'b1000, second, 4'b1001, 4'b1000};
    mag  = c.ramp ? 0 : c.mag;
    plan_q.delete();
    while (!quit && pulse < 1000) begin
      pulse++;
      for (int p = 0; p < 7 && !quit; p++) begin
        for (int k = 0; k < len[p] && !quit; k++) begin
          plan_q.push_back(mkvec(outs[p], mag, 1'b1, 1'b0));
          if (t == stop_edge - 1) begin
            if (p == 0) quit = 1;
            else pend = 1;
          end
          t++;
        end
      end
      if (!quit) begin
        if (c.ramp && mag < c.mag) mag++;
        if (pend || (c.npulse != 0 && pulse == c.npulse)) quit = 1;
      end
    end
    plan_q.push_back(mkvec(4'b0000, mag, 1'b0, 1'b1));
  endfunction

  function automatic cfg_t mk(int r, int e, int p1, int i, int p2, int d,
                              int m, int n, bit rmp, bit af);
    cfg_t c;
    c = '{rest: r, ext: e, ph1: p1, ipd: i, ph2: p2, dis: d,
          mag: m, npulse: n, ramp: rmp, af: af};
    return c;
  endfunction

  function automatic cfg_t rand_cfg();
    cfg_t c;
    c.rest   = $urandom_range(0, 4);
    c.ext    = $urandom_range(0, 3);
    c.ph1    = $urandom_range(0, 5);
    c.ipd    = $urandom_range(0, 3);
    c.ph2    = $urandom_range(0, 5);
    c.dis    = $urandom_range(0, 3);
    c.mag    = $urandom_range(0, 31);
    c.npulse = $urandom_range(0, 4);
    c.ramp   = 1'($urandom_range(0, 1));
    c.af     = 1'($urandom_range(0, 1));
    return c;
  endfunction

  task automatic drive_cfg(cfg_t c);
    cfg_rest         = CNT_W'(c.rest);
    cfg_ext          = CNT_W'(c.ext);
    cfg_ph1          = CNT_W'(c.ph1);
    cfg_ipd          = CNT_W'(c.ipd);
    cfg_ph2          = CNT_W'(c.ph2);
    cfg_dis          = CNT_W'(c.dis);
    cfg_mag          = MAG_W'(c.mag);
    cfg_ramp         = c.ramp;
    cfg_anodic_first = c.af;
    cfg_npulse       = NPULSE_W'(c.npulse);
  endtask

  task automatic scramble_cfg();
    cfg_rest         = CNT_W'($urandom_range(0, 9));
    cfg_ext          = CNT_W'($urandom_range(0, 9));
    cfg_ph1          = CNT_W'($urandom_range(0, 9));
    cfg_ipd          = CNT_W'($urandom_range(0, 9));
    cfg_ph2          = CNT_W'($urandom_range(0, 9));
    cfg_dis          = CNT_W'($urandom_range(0, 9));
    cfg_mag          = MAG_W'($urandom_range(0, 31));
    cfg_ramp         = 1'($urandom_range(0, 1));
    cfg_anodic_first = 1'($urandom_range(0, 1));
    cfg_npulse       = NPULSE_W'($urandom_range(0, 9));
  endtask

  // Called just after a rising edge; returns just after a rising edge.
  task automatic run_train(cfg_t c, int stop_edge, int rst_edge, bit noise, bit stop_with_start);
    int L;
    build_plan(c, stop_edge);
    L = plan_q.size() - 1;
    drive_cfg(c);
    start = 1'b1;
    stop  = stop_with_start;
    @(posedge clk);
    #1;
    start = 1'b0;
    stop  = 1'b0;
    if (rst_edge > 0) begin
      while (plan_q.size() > rst_edge) void'(plan_q.pop_back());
    end
    idle_mag = plan_q[plan_q.size()-1].mag;
    foreach (plan_q[i]) exp_q.push_back(plan_q[i]);
    for (int j = 1; j <= L; j++) begin
      stop = (j == stop_edge);
      rst  = (j == rst_edge);
      if (noise) begin
        start = (j < L) && ($urandom_range(0, 3) == 0);
        scramble_cfg();
      end
      if (rst) begin
        start = 1'($urandom_range(0, 1));
        stop  = 1'($urandom_range(0, 1));
      end
      @(posedge clk);
      #1;
      start = 1'b0;
      stop  = 1'b0;
      if (j == rst_edge) begin
        rst      = 1'b0;
        idle_mag = '0;
        break;
      end
    end
    for (int k = 0; k < 8 && exp_q.size() != 0; k++) begin
      @(posedge clk);
      #1;
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin : monitor
    vec_t act, e, idle_v;
    if (chk_en) begin
      act = '{en: EN_ST, cat: CAT_ST, ano: ANO_ST, dis: DIS_ST, mag: MAG_ST,
              busy: busy, done: done};
      if (act.busy === 1'b1 || act.done === 1'b1) begin
        n_tests++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL extra_output: got %s, required idle with no done", fmt(act));
        end else begin
          e = exp_q.pop_front();
          if (act !== e) begin
            n_fail++;
            $display("FAIL train_vec: got %s, required %s", fmt(act), fmt(e));
          end
        end
        n_tests++;
        if ((CAT_ST && ANO_ST) || ((CAT_ST || ANO_ST) && !EN_ST)) begin
          n_fail++;
          $display("FAIL phase_exclusive: got en=%b cat=%b ano=%b, required no overlap and en=1",
                   EN_ST, CAT_ST, ANO_ST);
        end
      end else begin
        n_tests++;
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          n_fail++;
          $display("FAIL missing_output: got %s, required %s", fmt(act), fmt(e));
        end else begin
          idle_v = mkvec(4'b0000, int'(idle_mag), 1'b0, 1'b0);
          if (act !== idle_v) begin
            n_fail++;
            $display("FAIL idle: got %s, required %s", fmt(act), fmt(idle_v));
          end
        end
      end
    end
  end

  initial begin
    cfg_t base, c;
    int   se;
    rst   = 1'b1;
    start = 1'b0;
    stop  = 1'b0;
    drive_cfg(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    repeat (3) @(posedge clk);
    #1;
    rst      = 1'b0;
    idle_mag = '0;
    chk_en   = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    base = mk(4, 2, 6, 3, 6, 2, 17, 1, 0, 0);
    run_train(base, 0, 0, 0, 0);                                       // single cathodic pulse
    run_train(mk(1, 1, 2, 1, 2, 1, 3, 5, 1, 1), 0, 0, 0, 0);           // anodic-first ramp
    run_train(mk(0, 0, 0, 0, 0, 0, 9, 3, 0, 1), 0, 0, 0, 0);           // zero durations
    run_train(mk(4, 2, 6, 3, 6, 2, 17, 0, 0, 0), 9, 0, 0, 0);          // stop mid-PH1
    run_train(mk(4, 2, 6, 3, 6, 2, 17, 0, 0, 0), 2, 0, 0, 0);          // stop in REST
    run_train(base, 25, 0, 0, 0);                                      // stop on final exit
    run_train(mk(4, 2, 6, 3, 6, 2, 12, 0, 1, 0), 8, 18, 1, 0);         // reset in PH2, stop pending
    run_train(mk(1, 1, 2, 1, 2, 1, 11, 2, 0, 1), 0, 0, 1, 1);          // start+stop, noisy cfg

    for (int n = 0; n < 25; n++) begin
      c  = rand_cfg();
      se = 0;
      if (c.npulse == 0) se = $urandom_range(1, 3 * period(c));
      else if ($urandom_range(0, 1) == 1) se = $urandom_range(1, period(c) * c.npulse);
      run_train(c, se, 0, 1, 1'($urandom_range(0, 1)));
    end

    repeat (3) @(posedge clk);
    #1;
    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
